// File: rtl/mem_loader_pkg.sv
// Shared constants and types for the byte-stream memory loader.
package mem_loader_pkg;

  // Frame header byte and word geometry
  localparam logic [7:0] SYNC_DEFAULT   = 8'hA5;
  localparam int         BYTES_PER_WORD = 4;

  // Loader FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BASE,
    ST_COUNT,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } state_t;

  // A count byte of zero stands for a full 256-word frame
  function automatic logic [8:0] frame_words(input logic [7:0] n);
    return (n == 8'h00) ? 9'd256 : {1'b0, n};
  endfunction

endpackage

// File: rtl/mem_loader_word_assembler.sv
// Collects little-endian bytes into a word and strobes word_ready one cycle
// after the last byte of the word is taken.
module mem_loader_word_assembler
  import mem_loader_pkg::*;
#(
  parameter int WORD = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            byte_vld,
  input  logic [7:0]      byte_in,
  output logic [1:0]      byte_idx,
  output logic [WORD-1:0] word,
  output logic            word_ready
);

  // Holds the first three bytes of the word; the newest byte enters at the
  // top so the oldest ends up in the low lane.
  logic [WORD-9:0] lanes;
  logic            last_lane;

  assign last_lane = (byte_idx == 2'(BYTES_PER_WORD - 1));

  // Lane shift register: data only, no reset needed
  always_ff @(posedge clk) begin
    if (byte_vld && !last_lane) begin
      lanes <= {byte_in, lanes[WORD-9:8]};
    end
  end

  // Byte counter, completed-word register and one-cycle word strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_idx   <= '0;
      word       <= '0;
      word_ready <= 1'b0;
    end else begin
      word_ready <= 1'b0;
      if (clear) begin
        byte_idx <= '0;
      end else if (byte_vld) begin
        if (last_lane) begin
          word       <= {byte_in, lanes};
          word_ready <= 1'b1;
          byte_idx   <= '0;
        end else begin
          byte_idx <= byte_idx + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Frame-based program/data loader: parses SYNC/BASE/N/payload/CHK frames from
// a host byte link, writes assembled words into processor memory and holds
// the core in stall while a frame is in flight or has failed its checksum.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int         WORD   = 32,
  parameter int         ADDR_W = 8,
  parameter logic [7:0] SYNC   = SYNC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_write,
  output logic [WORD-1:0]   mem_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              stall_o,
  output logic              load_done,
  output logic              load_err
);

  state_t            state;
  logic [7:0]        chk;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] word_idx;
  logic [8:0]        words_left;
  logic [1:0]        byte_idx;
  logic              accept;
  logic              asm_vld;
  logic              asm_clear;
  logic              word_done;

  assign accept    = rx_valid & rx_ready;
  assign asm_vld   = accept && (state == ST_DATA);
  assign asm_clear = accept && (state == ST_COUNT);
  assign word_done = asm_vld && (byte_idx == 2'(BYTES_PER_WORD - 1));

  // The assembler's registered strobe and word are the memory write port:
  // they appear one cycle after the fourth byte's handshake.
  mem_loader_word_assembler #(
    .WORD(WORD)
  ) u_word_assembler (
    .clk       (clk),
    .reset     (reset),
    .clear     (asm_clear),
    .byte_vld  (asm_vld),
    .byte_in   (rx_data),
    .byte_idx  (byte_idx),
    .word      (mem_in),
    .word_ready(mem_write)
  );

  // Frame FSM with running checksum, address counter and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      rx_ready   <= 1'b1;
      stall_o    <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      chk        <= '0;
      base       <= '0;
      word_idx   <= '0;
      words_left <= '0;
      mem_addr   <= '0;
    end else begin
      load_done <= 1'b0;
      case (state)
        // IDLE and ERR both discard everything but SYNC; ERR keeps the core held
        ST_IDLE, ST_ERR: begin
          if (accept && rx_data == SYNC) begin
            state    <= ST_BASE;
            stall_o  <= 1'b1;
            load_err <= 1'b0;
            chk      <= '0;
          end
        end
        ST_BASE: begin
          if (accept) begin
            base  <= ADDR_W'(rx_data);
            chk   <= chk ^ rx_data;
            state <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (accept) begin
            words_left <= frame_words(rx_data);
            word_idx   <= '0;
            chk        <= chk ^ rx_data;
            state      <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (accept) begin
            chk <= chk ^ rx_data;
            if (word_done) begin
              // Address is latched here so it lines up with the write strobe
              mem_addr   <= base + word_idx;
              word_idx   <= word_idx + 1'b1;
              words_left <= words_left - 9'd1;
              if (words_left == 9'd1) begin
                state <= ST_CHECK;
              end
            end
          end
        end
        ST_CHECK: begin
          if (accept) begin
            if (rx_data == chk) begin
              state     <= ST_DONE;
              load_done <= 1'b1;
              rx_ready  <= 1'b0;
            end else begin
              state    <= ST_ERR;
              load_err <= 1'b1;
            end
          end
        end
        // Single cycle: release the core on the way back to IDLE
        ST_DONE: begin
          state    <= ST_IDLE;
          stall_o  <= 1'b0;
          rx_ready <= 1'b1;
        end
        default: begin
          state    <= ST_IDLE;
          rx_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
